control_unit: RTL and testbench

Hardwired sequencer for the 16-bit single-bus microcontroller datapath. Fetches instructions through PC/MAR/MDR/memory into IR, decodes IR, and drives every register latch, tri-state enable, ALU, memory and I/O control strobe, one micro-step per clock. Sits beside the datapath top level: its outputs wire directly to the datapath control inputs, and `MFC` and `ir` are fed back to it.

---
 rtl/ctrl_pkg.sv | 77 +++++++
 rtl/control_unit_if.sv | 34 +++
 rtl/instr_decoder.sv | 34 +++
 rtl/control_unit.sv | 140 ++++++++++++++
 tb/tb_control_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired sequencer: state codes, opcodes, IR field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    // Cycles the sequencer waits for MFC before declaring a memory fault.
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    // IR field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_BIT = 7;

    // Opcodes with op[3]=1; op[3]=0 is the ALU group.
    localparam logic [3:0] OP_MOV   = 4'b1000;
    localparam logic [3:0] OP_MOVI  = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_IN    = 4'b1100;
    localparam logic [3:0] OP_OUT   = 4'b1101;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Sequencer states
    typedef logic [4:0] state_t;
    localparam state_t ST_IDLE = 5'd0;
    localparam state_t ST_F0   = 5'd1;
    localparam state_t ST_F1   = 5'd2;
    localparam state_t ST_F2   = 5'd3;
    localparam state_t ST_DEC  = 5'd4;
    localparam state_t ST_A0   = 5'd5;
    localparam state_t ST_A1   = 5'd6;
    localparam state_t ST_A2   = 5'd7;
    localparam state_t ST_A3   = 5'd8;
    localparam state_t ST_MOV  = 5'd9;
    localparam state_t ST_MOVI = 5'd10;
    localparam state_t ST_L0   = 5'd11;
    localparam state_t ST_L1   = 5'd12;
    localparam state_t ST_L2   = 5'd13;
    localparam state_t ST_S0   = 5'd14;
    localparam state_t ST_S1   = 5'd15;
    localparam state_t ST_S2   = 5'd16;
    localparam state_t ST_I0   = 5'd17;
    localparam state_t ST_I1   = 5'd18;
    localparam state_t ST_OUT  = 5'd19;
    localparam state_t ST_NOP  = 5'd20;
    localparam state_t ST_HALT = 5'd21;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_MOV,
        CLS_MOVI,
        CLS_LOAD,
        CLS_STORE,
        CLS_IN,
        CLS_OUT,
        CLS_NOP,
        CLS_HALT
    } instr_cls_t;

    typedef struct packed {
        instr_cls_t cls;
        logic [3:0] rd_oh;
        logic [3:0] rs_oh;
        logic       imm;
    } dec_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the datapath (strobes out, ir/MFC/run back).
// Latency: n/a (wires only).
// Backpressure: none; MFC is the only completion signal, all strobes are single-cycle levels.
interface control_unit_if;
    // datapath/system -> sequencer
    logic        run;
    logic [15:0] ir;
    logic        MFC;
    // sequencer -> datapath
    logic        PCOutEn, PCInc, MARin, memEN, memRW;
    logic        MDRwriteEN, MDRreadEN, MDRout, IREN;
    logic        ALUin0, ALUin1, ALUOutLatch, ALUOutEn, ALUImmOut, MOVImmOut;
    logic        p0Latch, p0Out, p1Latch, p1Out;
    logic [3:0]  rLatch, rOut;
    logic        halted, fault;

    modport master (
        input  run, ir, MFC,
        output PCOutEn, PCInc, MARin, memEN, memRW,
        output MDRwriteEN, MDRreadEN, MDRout, IREN,
        output ALUin0, ALUin1, ALUOutLatch, ALUOutEn, ALUImmOut, MOVImmOut,
        output p0Latch, p0Out, p1Latch, p1Out,
        output rLatch, rOut, halted, fault
    );

    modport slave (
        output run, ir, MFC,
        input  PCOutEn, PCInc, MARin, memEN, memRW,
        input  MDRwriteEN, MDRreadEN, MDRout, IREN,
        input  ALUin0, ALUin1, ALUOutLatch, ALUOutEn, ALUImmOut, MOVImmOut,
        input  p0Latch, p0Out, p1Latch, p1Out,
        input  rLatch, rOut, halted, fault
    );
endinterface

// File: rtl/instr_decoder.sv
// Instruction decoder: IR upper bits -> instruction class, Rd/Rs one-hot, immediate flag.
// Latency: combinational. Ports: ir_hi = ir[15:7] in, dec out.
// Backpressure: none. The low IR bits carry the immediate and never affect sequencing.
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [15:7] ir_hi,
    output dec_t        dec
);

    logic [3:0] op;

    always_comb begin
        op        = ir_hi[OP_MSB:OP_LSB];
        dec.rd_oh = onehot4(ir_hi[RD_MSB:RD_LSB]);
        dec.rs_oh = onehot4(ir_hi[RS_MSB:RS_LSB]);
        dec.imm   = ir_hi[IMM_BIT];
        dec.cls   = CLS_ALU;
        // op[3]=0 is the whole ALU group; the ALU decodes ir[14:12] itself.
        if (op[3]) begin
            case (op)
                OP_MOV:   dec.cls = CLS_MOV;
                OP_MOVI:  dec.cls = CLS_MOVI;
                OP_LOAD:  dec.cls = CLS_LOAD;
                OP_STORE: dec.cls = CLS_STORE;
                OP_IN:    dec.cls = CLS_IN;
                OP_OUT:   dec.cls = CLS_OUT;
                OP_NOP:   dec.cls = CLS_NOP;
                default:  dec.cls = CLS_HALT;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetch/decode/execute FSM driving every datapath strobe, one micro-step per clock.
// Latency: outputs combinational from state, ir and MFC. Ports: clk, rst (async high), cu (master bundle).
// Backpressure: memory wait states hold until MFC; 15 cycles without MFC sets sticky fault and halts.
module control_unit
    import ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master cu
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             mem_wait;
    logic             timeout;
    dec_t             dec;

    instr_decoder u_dec (
        .ir_hi (cu.ir[15:7]),
        .dec   (dec)
    );

    // Counter is zero whenever not waiting, so it is cleared on every wait entry.
    assign mem_wait = (state_q == ST_F1) || (state_q == ST_L1) || (state_q == ST_S2);
    assign timeout  = mem_wait && !cu.MFC && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        fault_d = fault_q | timeout;
        cnt_d   = mem_wait ? cnt_q + 1'b1 : '0;
        case (state_q)
            ST_IDLE: if (cu.run) state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1: begin
                if (cu.MFC)     state_d = ST_F2;
                else if (timeout) state_d = ST_HALT;
            end
            ST_F2:   state_d = ST_DEC;
            ST_DEC: begin
                case (dec.cls)
                    CLS_ALU:   state_d = ST_A0;
                    CLS_MOV:   state_d = ST_MOV;
                    CLS_MOVI:  state_d = ST_MOVI;
                    CLS_LOAD:  state_d = ST_L0;
                    CLS_STORE: state_d = ST_S0;
                    CLS_IN:    state_d = ST_I0;
                    CLS_OUT:   state_d = ST_OUT;
                    CLS_NOP:   state_d = ST_NOP;
                    default:   state_d = ST_HALT;
                endcase
            end
            ST_A0:   state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_A3;
            ST_L0:   state_d = ST_L1;
            ST_L1: begin
                if (cu.MFC)     state_d = ST_L2;
                else if (timeout) state_d = ST_HALT;
            end
            ST_S0:   state_d = ST_S1;
            ST_S1:   state_d = ST_S2;
            ST_S2: begin
                if (cu.MFC)     state_d = ST_F0;
                else if (timeout) state_d = ST_HALT;
            end
            ST_I0:   state_d = ST_I1;
            ST_A3, ST_MOV, ST_MOVI, ST_L2, ST_I1, ST_OUT, ST_NOP:
                     state_d = ST_F0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Output decode. Each state enables at most one bus driver.
    always_comb begin
        cu.PCOutEn     = 1'b0;
        cu.PCInc       = 1'b0;
        cu.MARin       = 1'b0;
        cu.memEN       = 1'b0;
        cu.memRW       = 1'b0;
        cu.MDRwriteEN  = 1'b0;
        cu.MDRreadEN   = 1'b0;
        cu.MDRout      = 1'b0;
        cu.IREN        = 1'b0;
        cu.ALUin0      = 1'b0;
        cu.ALUin1      = 1'b0;
        cu.ALUOutLatch = 1'b0;
        cu.ALUOutEn    = 1'b0;
        cu.ALUImmOut   = 1'b0;
        cu.MOVImmOut   = 1'b0;
        cu.p0Latch     = 1'b0;
        cu.p0Out       = 1'b0;
        cu.p1Latch     = 1'b0;
        cu.p1Out       = 1'b0;
        cu.rLatch      = 4'b0000;
        cu.rOut        = 4'b0000;
        case (state_q)
            ST_F0:   begin cu.PCOutEn = 1'b1; cu.MARin = 1'b1; end
            ST_F1:   begin cu.memEN = 1'b1; cu.MDRreadEN = cu.MFC; end
            ST_F2:   begin cu.MDRout = 1'b1; cu.IREN = 1'b1; cu.PCInc = 1'b1; end
            ST_A0:   begin cu.rOut = dec.rd_oh; cu.ALUin0 = 1'b1; end
            ST_A1: begin
                if (dec.imm) cu.ALUImmOut = 1'b1;
                else         cu.rOut      = dec.rs_oh;
                cu.ALUin1 = 1'b1;
            end
            ST_A2:   cu.ALUOutLatch = 1'b1;
            ST_A3:   begin cu.ALUOutEn = 1'b1; cu.rLatch = dec.rd_oh; end
            ST_MOV:  begin cu.rOut = dec.rs_oh; cu.rLatch = dec.rd_oh; end
            ST_MOVI: begin cu.MOVImmOut = 1'b1; cu.rLatch = dec.rd_oh; end
            ST_L0:   begin cu.rOut = dec.rs_oh; cu.MARin = 1'b1; end
            ST_L1:   begin cu.memEN = 1'b1; cu.MDRreadEN = cu.MFC; end
            ST_L2:   begin cu.MDRout = 1'b1; cu.rLatch = dec.rd_oh; end
            ST_S0:   begin cu.rOut = dec.rs_oh; cu.MARin = 1'b1; end
            ST_S1:   begin cu.rOut = dec.rd_oh; cu.MDRwriteEN = 1'b1; end
            ST_S2:   begin cu.memEN = 1'b1; cu.memRW = 1'b1; end
            ST_I0:   cu.p1Latch = 1'b1;
            ST_I1:   begin cu.p1Out = 1'b1; cu.rLatch = dec.rd_oh; end
            ST_OUT:  begin cu.rOut = dec.rd_oh; cu.p0Latch = 1'b1; end
            default: ;
        endcase
    end

    assign cu.halted = (state_q == ST_HALT);
    assign cu.fault  = fault_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: micro-step output vectors per state, memory timeout, halt, bus exclusivity.
// Latency: inputs driven on falling edge, outputs sampled 1ns later.
// Backpressure: bench plays the memory by driving MFC per step.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst;
    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .cu  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Output vector bit positions (bench-local packing)
    localparam logic [28:0] PCO    = 29'd1 << 28;
    localparam logic [28:0] PCINC  = 29'd1 << 27;
    localparam logic [28:0] MARIN  = 29'd1 << 26;
    localparam logic [28:0] MEMEN  = 29'd1 << 25;
    localparam logic [28:0] MEMRW  = 29'd1 << 24;
    localparam logic [28:0] MDRWR  = 29'd1 << 23;
    localparam logic [28:0] MDRRD  = 29'd1 << 22;
    localparam logic [28:0] MDROUT = 29'd1 << 21;
    localparam logic [28:0] IREN   = 29'd1 << 20;
    localparam logic [28:0] ALUIN0 = 29'd1 << 19;
    localparam logic [28:0] ALUIN1 = 29'd1 << 18;
    localparam logic [28:0] ALUOL  = 29'd1 << 17;
    localparam logic [28:0] ALUOE  = 29'd1 << 16;
    localparam logic [28:0] ALUIMM = 29'd1 << 15;
    localparam logic [28:0] MOVIMM = 29'd1 << 14;
    localparam logic [28:0] P0L    = 29'd1 << 13;
    localparam logic [28:0] P0O    = 29'd1 << 12;
    localparam logic [28:0] P1L    = 29'd1 << 11;
    localparam logic [28:0] P1O    = 29'd1 << 10;
    localparam logic [28:0] HALTED = 29'd1 << 1;
    localparam logic [28:0] FAULT  = 29'd1;

    function automatic logic [28:0] RL(input logic [3:0] m);
        return {19'd0, m, 6'd0};
    endfunction

    function automatic logic [28:0] RO(input logic [3:0] m);
        return {23'd0, m, 2'd0};
    endfunction

    function automatic logic [28:0] outs();
        return {bus.PCOutEn, bus.PCInc, bus.MARin, bus.memEN, bus.memRW,
                bus.MDRwriteEN, bus.MDRreadEN, bus.MDRout, bus.IREN,
                bus.ALUin0, bus.ALUin1, bus.ALUOutLatch, bus.ALUOutEn,
                bus.ALUImmOut, bus.MOVImmOut,
                bus.p0Latch, bus.p0Out, bus.p1Latch, bus.p1Out,
                bus.rLatch, bus.rOut, bus.halted, bus.fault};
    endfunction

    function automatic int drivers();
        return $countones(bus.rOut) + int'(bus.PCOutEn) + int'(bus.ALUOutEn) +
               int'(bus.MDRout) + int'(bus.p0Out) + int'(bus.p1Out) +
               int'(bus.ALUImmOut) + int'(bus.MOVImmOut);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive MFC on the falling edge, then compare the full output vector.
    task automatic step(input string tag, input logic mfc, input logic [28:0] exp);
        @(negedge clk);
        bus.MFC = mfc;
        #1;
        chk(tag, 32'(outs()), 32'(exp));
    endtask

    // F0, F1 (MFC on wait cycle 'waits'), F2, DEC; IR takes irv while in F2.
    task automatic fetch(input string tag, input logic [15:0] irv, input int waits);
        step({tag, ".f0"}, 1'b0, PCO | MARIN);
        for (int i = 1; i < waits; i++) step({tag, ".f1w"}, 1'b0, MEMEN);
        step({tag, ".f1"}, 1'b1, MEMEN | MDRRD);
        step({tag, ".f2"}, 1'b0, MDROUT | IREN | PCINC);
        bus.ir = irv;
        step({tag, ".dec"}, 1'b0, '0);
    endtask

    initial begin
        rst     = 1'b1;
        bus.run = 1'b0;
        bus.ir  = 16'h0000;
        bus.MFC = 1'b0;

        // Reset and idle behaviour
        @(negedge clk); #1;
        chk("rst_outs", 32'(outs()), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("idle_norun", 32'(outs()), 32'd0);
        step("idle_norun2", 1'b0, '0);
        bus.run = 1'b1;
        step("f0", 1'b0, PCO | MARIN);
        step("f1_wait", 1'b0, MEMEN);
        @(negedge clk); rst = 1'b1; #1;
        chk("rst_mid_f1", 32'(outs()), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_idle", 32'(outs()), 32'd0);

        // ALU immediate: op1, Rd=3, I=1; fetch with MFC on the second wait cycle
        fetch("alui", 16'h1C80, 2);
        bus.run = 1'b0;   // no longer sampled once running
        step("alui.a0", 1'b0, RO(4'b1000) | ALUIN0);
        step("alui.a1", 1'b0, ALUIMM | ALUIN1);
        step("alui.a2", 1'b0, ALUOL);
        step("alui.a3", 1'b0, ALUOE | RL(4'b1000));

        // ALU register: op2, Rd=1, Rs=2, I=0
        fetch("alur", 16'h2600, 1);
        step("alur.a0", 1'b0, RO(4'b0010) | ALUIN0);
        step("alur.a1", 1'b0, RO(4'b0100) | ALUIN1);
        step("alur.a2", 1'b0, ALUOL);
        step("alur.a3", 1'b0, ALUOE | RL(4'b0010));

        // MOV r1 <= r2, MFC outside a wait state must be ignored
        fetch("mov", 16'h8600, 1);
        step("mov.x", 1'b1, RO(4'b0100) | RL(4'b0010));

        // MOVi r3 <= imm
        fetch("movi", 16'h9C00, 1);
        step("movi.x", 1'b0, MOVIMM | RL(4'b1000));

        // LOAD r1 <= mem[r0], MFC on the third wait cycle
        fetch("ld", 16'hA400, 1);
        step("ld.l0", 1'b0, RO(4'b0001) | MARIN);
        step("ld.l1w1", 1'b0, MEMEN);
        step("ld.l1w2", 1'b0, MEMEN);
        step("ld.l1", 1'b1, MEMEN | MDRRD);
        step("ld.l2", 1'b0, MDROUT | RL(4'b0010));

        // STORE mem[r1] <= r2
        fetch("st", 16'hB900, 1);
        step("st.s0", 1'b1, RO(4'b0010) | MARIN);
        step("st.s1", 1'b0, RO(4'b0100) | MDRWR);
        step("st.s2", 1'b1, MEMEN | MEMRW);

        // IN r2 <= P1
        fetch("in", 16'hC800, 1);
        step("in.i0", 1'b0, P1L);
        step("in.i1", 1'b0, P1O | RL(4'b0100));

        // OUT P0 <= r1
        fetch("out", 16'hD400, 1);
        step("out.x", 1'b0, RO(4'b0010) | P0L);

        // NOP
        fetch("nop", 16'hE000, 1);
        step("nop.x", 1'b0, '0);
        step("end.f0", 1'b0, PCO | MARIN);

        // Random instruction stream (no HALT): bus has at most one driver
        for (int c = 0; c < 300; c++) begin
            logic [31:0] r;
            @(negedge clk);
            r = $urandom;
            if (r[15:12] == 4'hF) r[15:12] = 4'hE;
            bus.ir  = r[15:0];
            bus.MFC = r[16];
            #1;
            chk("bus_onehot", 32'(drivers() <= 1), 32'd1);
        end

        // LOAD with MFC never returned: fault and halt after 15 wait cycles
        @(negedge clk); rst = 1'b1; bus.MFC = 1'b0; #1;
        chk("rst2_outs", 32'(outs()), 32'd0);
        @(negedge clk); rst = 1'b0; bus.run = 1'b1; #1;
        chk("rst2_idle", 32'(outs()), 32'd0);
        fetch("to", 16'hA400, 1);
        step("to.l0", 1'b0, RO(4'b0001) | MARIN);
        for (int i = 0; i < 15; i++) step("to.wait", 1'b0, MEMEN);
        step("to.halt", 1'b0, HALTED | FAULT);
        step("to.hold", 1'b1, HALTED | FAULT);
        step("to.hold2", 1'b0, HALTED | FAULT);
        @(negedge clk); rst = 1'b1; #1;
        chk("fault_clr", 32'(outs()), 32'd0);

        // HALT instruction holds until reset
        @(negedge clk); rst = 1'b0; #1;
        chk("rst3_idle", 32'(outs()), 32'd0);
        fetch("hlt", 16'hF000, 1);
        step("hlt.h0", 1'b0, HALTED);
        for (int i = 0; i < 4; i++) step("hlt.hold", 1'b1, HALTED);
        @(negedge clk); rst = 1'b1; #1;
        chk("hlt.rst", 32'(outs()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
